pattern_detector_param: RTL

- Parametrised successor to the team's fixed two-bit Mealy pattern recogniser.
- Watches a serial bit stream qualified by a valid strobe and flags when the last PAT_W accepted bits match a runtime-programmable pattern. Individual bits can be masked as don't-care.
- Supports overlapping and non-overlapping detection modes.
- Keeps a saturating match counter for status readout.
- Sits between the serial input front end and the control/status logic.

---
 rtl/pattern_det_pkg.sv | 21 ++
 rtl/sat_counter.sv | 45 ++++
 rtl/pattern_detector_param.sv | 107 ++++++++++
 3 files changed

// File: rtl/pattern_det_pkg.sv
// Shared types and helpers for the parametrised pattern detector.
package pattern_det_pkg;

  localparam int unsigned MAX_PAT_W = 16;

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } det_state_t;

  // True when every cared-for bit of hist_ext equals the pattern bit.
  // Callers zero-extend all three operands, so unused upper mask bits are don't-care.
  function automatic logic masked_match(
    input logic [MAX_PAT_W-1:0] hist_ext,
    input logic [MAX_PAT_W-1:0] pattern,
    input logic [MAX_PAT_W-1:0] mask
  );
    return &(~(hist_ext ^ pattern) | ~mask);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with sticky saturation flag and synchronous clear.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  // Next count: clear has priority, increment stops at all ones.
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
      if (&count_d) begin
        sat_d = 1'b1;
      end
    end
  end

  // Counter state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/pattern_detector_param.sv
// Mealy detector for a programmable, maskable PAT_W-bit serial pattern.
module pattern_detector_param
  import pattern_det_pkg::*;
#(
  parameter int unsigned      PAT_W       = 4,
  parameter int unsigned      CNT_W       = 8,
  parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(1),
  parameter logic [PAT_W-1:0] RST_MASK    = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             a_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             armed
);

  localparam int unsigned      FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  det_state_t        state_q, state_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [PAT_W-1:0]  mask_q, mask_d;
  logic              overlap_q, overlap_d;
  logic [PAT_W-1:0]  hist_ext;
  logic              hit;

  // Window is the stored history plus the bit arriving this cycle; slicing it
  // rather than hist_q keeps the shift legal for PAT_W = 2.
  assign hist_ext = {hist_q, a};
  assign hit      = masked_match(MAX_PAT_W'(hist_ext), MAX_PAT_W'(pattern_q), MAX_PAT_W'(mask_q));
  assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

  assign y     = reset && !cfg_load && a_valid && (state_q == S_ARMED) && hit;
  assign armed = (state_q == S_ARMED);

  // Next history, fill level, configuration and state.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    mask_d    = mask_q;
    overlap_d = overlap_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      mask_d    = cfg_mask;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = S_FILL;
    end else if (a_valid) begin
      if (y && !overlap_q) begin
        hist_d  = '0;
        fill_d  = '0;
        state_d = S_FILL;
      end else begin
        hist_d  = hist_ext[PAT_W-2:0];
        fill_d  = fill_inc;
        state_d = (fill_inc == FILL_MAX) ? S_ARMED : S_FILL;
      end
    end
  end

  // Detector registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FILL;
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= RST_PATTERN;
      mask_q    <= RST_MASK;
      overlap_q <= 1'b1;
      y_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      overlap_q <= overlap_d;
      y_q       <= y;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (y),
    .clr  (cnt_clr),
    .count(match_cnt),
    .sat  (cnt_sat)
  );

endmodule
